// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: default widths and the hardwired-zero register index.
// The mux, the ALU and the register file all take their defaults from here.
package mips_pkg;

  localparam int DATA_W_DEFAULT   = 32;
  localparam int ADDR_W_DEFAULT   = 5;
  localparam int NUM_REGS_DEFAULT = 1 << ADDR_W_DEFAULT;
  localparam int REG_ZERO         = 0;

  // True when the index names the hardwired-zero register.
  function automatic logic is_reg_zero(input logic [ADDR_W_DEFAULT-1:0] addr);
    return addr == ADDR_W_DEFAULT'(REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// One combinational read port: forces r0 to zero and forwards same-cycle write data
// (write-first) when the write hits the register being read.
module reg_file_rdport
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] stored,
  input  logic              bypass_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic read_zero;
  logic hit;

  assign read_zero = (raddr == ADDR_W'(REG_ZERO));
  // A hit on a nonzero read address implies a nonzero write address.
  assign hit       = bypass_en && (raddr == waddr);

  always_comb begin
    rdata = stored;
    if (read_zero) begin
      rdata = '0;
    end else if (hit) begin
      rdata = wdata;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32-entry, two-read / one-write register file with zero-latency reads,
// write-first bypass and a hardwired-zero r0.
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int NUM_PORTS = 2;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              write_en;
  logic              bypass_en;

  logic [ADDR_W-1:0] rd_addr [NUM_PORTS];
  logic [DATA_W-1:0] rd_data [NUM_PORTS];

  // Reset wins over a write, and also hides the write from the read ports.
  assign bypass_en = we && !rst;
  assign write_en  = bypass_en && (waddr != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[waddr] <= wdata;
    end
  end

  assign rd_addr[0] = raddr_a;
  assign rd_addr[1] = raddr_b;
  assign rdata_a    = rd_data[0];
  assign rdata_b    = rd_data[1];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rdport
      reg_file_rdport #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
      ) u_rdport (
        .raddr    (rd_addr[gi]),
        .stored   (regs[rd_addr[gi]]),
        .bypass_en(bypass_en),
        .waddr    (waddr),
        .wdata    (wdata),
        .rdata    (rd_data[gi])
      );
    end
  endgenerate

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, meaning register and data width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 5, meaning register address width; register count is 2**ADDR_W (32).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 we  input  1  write enable.
REQ-006 waddr  input  ADDR_W  write register index.
REQ-007 wdata  input  DATA_W  write data.
REQ-008 raddr_a  input  ADDR_W  read port A register index (rs).
REQ-009 raddr_b  input  ADDR_W  read port B register index (rt).
REQ-010 rdata_a  output  DATA_W  read port A data; it feeds the operand-A datapath.
REQ-011 rdata_b  output  DATA_W  read port B data; it feeds input A of the downstream 32-bit 2:1 ALU-source mux.

Function
REQ-012 The block SHALL hold 32 registers of DATA_W bits, r0..r31.
REQ-013 Reads SHALL be combinational, with zero-cycle latency from raddr_x to rdata_x.
REQ-014 A write SHALL occur on the rising clk edge when we=1, rst=0 and waddr!=0; the value SHALL be readable without bypass from the next cycle.
REQ-015 Register r0 SHALL always read 0; writes to waddr=0 SHALL be ignored, including for bypass.
REQ-016 Bypass SHALL apply when we=1, waddr!=0 and raddr_x==waddr in the same cycle: rdata_x SHALL equal wdata (write-first), not the stored value.
REQ-017 Both ports addressing the same register SHALL return identical data, bypass included.
REQ-018 When we=0, the stored contents SHALL be unchanged and no bypass SHALL occur.
REQ-019 Reads SHALL have no side effects, and any address combination SHALL be legal.
REQ-020 Back-to-back writes to the same register SHALL leave the last value written.

Reset
REQ-021 On a rising clk edge with rst=1, all 32 registers SHALL be cleared to 0 in that single cycle.
REQ-022 rst SHALL take priority over we; a write in a reset cycle SHALL be dropped.
REQ-023 Bypass SHALL be suppressed while rst=1, so that rdata reflects stored contents.
REQ-024 The block SHALL accept reset asserted at any time, including mid-sequence; the first write after rst deasserts SHALL be honoured in the very next cycle.
REQ-025 Outputs SHALL read 0 for every address after the reset edge and until the next write.

Structure
REQ-026 DATA_W, ADDR_W and NUM_REGS defaults, plus the constant REG_ZERO=0, SHALL live in the shared package mips_pkg, used alike by the mux, ALU and this block.
REQ-027 The storage array and write logic SHALL be in reg_file itself.
REQ-028 Each read port SHALL be one instance of a sub-module reg_file_rdport, which handles r0 masking, bypass compare and output selection, and is instantiated twice.
REQ-029 There SHALL be no latches, and no asynchronous logic on rst.

Verification
REQ-030 Reset check: assert rst for 1 cycle, then read all 32 addresses on both ports -> every read = 32'h0000_0000.
REQ-031 Write then read: we=1, waddr=5, wdata=32'hDEAD_BEEF, then next cycle raddr_a=5, raddr_b=5 with we=0 -> rdata_a = rdata_b = 32'hDEAD_BEEF.
REQ-032 r0 immunity: we=1, waddr=0, wdata=32'hFFFF_FFFF with raddr_a=0 in the same and the next cycle -> rdata_a = 0 both cycles.
REQ-033 Bypass: r7 holds 32'h1111_1111; drive we=1, waddr=7, wdata=32'h2222_2222 with raddr_b=7 -> rdata_b = 32'h2222_2222 in the same cycle, and still 32'h2222_2222 next cycle with we=0.
REQ-034 Reset priority: r3 = 32'h0000_00AA; drive rst=1, we=1, waddr=3, wdata=32'h55 -> after the edge r3 reads 0; next cycle rst=0 and a write of 32'h77 -> r3 reads 32'h77.
REQ-035 Mux chain: raddr_b=9 with r9 = 32'h0000_FFFF drives the downstream mux A input, B=0 -> mux out = 32'h0000_FFFF with sel=0 and 32'h0000_0000 with sel=1.
